// File: rtl/rr_arbiter_locked_burst_pkg.sv
// Shared types and index helpers for the locked-burst arbiter.
// Widths sized for the largest supported requester count.
package arb_pkg;

  localparam int MAX_N = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic logic [IDX_W-1:0] onehot_to_idx(
    input logic [MAX_N-1:0] oh
  );
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [MAX_N-1:0] idx_to_onehot(
    input logic [IDX_W-1:0] idx
  );
    return MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: rotate req so ptr sits at bit 0, find the
// first set bit, then rotate the offset back to an absolute index.
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int ID_W = $clog2(N);
  localparam logic [ID_W:0] NW = (ID_W+1)'(N);

  logic [N-1:0]    rot;
  logic [ID_W-1:0] off;
  logic [ID_W:0]   pos;
  logic [ID_W:0]   sum;

  // Rotate, find-first from ptr, and map the offset back modulo N.
  always_comb begin
    rot = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (ID_W+1)'(k);
      if (pos >= NW) pos = pos - NW;
      rot[k] = req[pos[ID_W-1:0]];
    end
    found = 1'b0;
    off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = ID_W'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NW) sum = sum - NW;
    idx = sum[ID_W-1:0];
  end

endmodule

// File: rtl/rr_arbiter_locked_burst.sv
// Round-robin arbiter that locks the grant for a whole burst.
// Optional forced release after MAX_HOLD cycles: ARB_HOLD_TIMEOUT_EN.
module rr_arbiter_locked_burst
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 16,
  localparam int ID_W     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    last,
  input  logic            res_ready,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id,
  output logic            beat_fire,
  output logic            timeout
);

  localparam logic [ID_W:0] NW = (ID_W+1)'(N);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] owner_q, owner_d;

  logic            found;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] cur;
  logic [ID_W:0]   cur_inc;
  logic [ID_W-1:0] nxt_ptr;
  logic            active;
  logic            fire;
  logic            fin;
  logic            hold_hit;
  logic            to;

  rr_priority_pick #(
    .N(N)
  ) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .found(found),
    .idx  (win)
  );

  // Current candidate, its beat handshake and the rotated pointer.
  always_comb begin
    cur     = (state_q == ARB_LOCKED) ? owner_q : win;
    active  = !rst && ((state_q == ARB_LOCKED) || found);
    fire    = active && req[cur] && res_ready;
    fin     = fire && last[cur];
    cur_inc = {1'b0, cur} + (ID_W+1)'(1);
    if (cur_inc == NW) cur_inc = '0;
    nxt_ptr = cur_inc[ID_W-1:0];
    to      = active && hold_hit && !fin;
  end

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [HW-1:0] hold_q, hold_d;

  // Cycles spent in the current lock.
  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end

  // Count only while staying locked; anything else restarts at 0.
  always_comb begin
    hold_d = '0;
    if (state_q == ARB_LOCKED && state_d == ARB_LOCKED)
      hold_d = hold_q + HW'(1);
    hold_hit = (state_q == ARB_LOCKED) && (hold_q == HOLD_LAST);
  end
`else
  logic [31:0] unused_hold;
  assign unused_hold = 32'(MAX_HOLD);
  assign hold_hit    = 1'b0;
`endif

  // State, pointer and owner registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Lock on a multi-beat or stalled beat; release on last or timeout.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (found) begin
          if (fin) begin
            ptr_d = nxt_ptr;
          end else begin
            state_d = ARB_LOCKED;
            owner_d = win;
          end
        end
      end
      ARB_LOCKED: begin
        if (fin || to) begin
          state_d = ARB_IDLE;
          ptr_d   = nxt_ptr;
        end
      end
    endcase
  end

  // Drive the one-hot grant and derived outputs.
  always_comb begin
    grant = '0;
    if (active) grant = N'(idx_to_onehot(IDX_W'(cur)));
    grant_valid = |grant;
    grant_id    = ID_W'(onehot_to_idx(MAX_N'(grant)));
    beat_fire   = fire;
    timeout     = to;
  end

endmodule

// File: tb/tb_rr_arbiter_locked_burst.sv
// Bench for rr_arbiter_locked_burst: directed table, burst corner
// sequences, an N=3 wrap check and a randomized run vs a model.
module tb_rr_arbiter_locked_burst;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int MAXH = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req, last;
  logic       rdy;
  logic [3:0] g;
  logic       gv;
  logic [1:0] gid;
  logic       bf, to;

  logic       rst3;
  logic [2:0] req3, last3;
  logic       rdy3;
  logic [2:0] g3;
  logic       gv3;
  logic [1:0] gid3;
  logic       bf3, to3;

  int total = 0;
  int bad   = 0;

  rr_arbiter_locked_burst #(.N(4), .MAX_HOLD(MAXH)) u_dut (
    .clk(clk), .rst(rst), .req(req), .last(last),
    .res_ready(rdy), .grant(g), .grant_valid(gv),
    .grant_id(gid), .beat_fire(bf), .timeout(to)
  );

  rr_arbiter_locked_burst #(.N(3), .MAX_HOLD(MAXH)) u_dut3 (
    .clk(clk), .rst(rst3), .req(req3), .last(last3),
    .res_ready(rdy3), .grant(g3), .grant_valid(gv3),
    .grant_id(gid3), .beat_fire(bf3), .timeout(to3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] q,
                       input logic [3:0] l, input logic y);
    @(posedge clk);
    #1;
    rst = r; req = q; last = l; rdy = y;
    #4;
  endtask

  task automatic drive3(input logic r, input logic [2:0] q,
                        input logic [2:0] l);
    @(posedge clk);
    #1;
    rst3 = r; req3 = q; last3 = l; rdy3 = 1'b1;
    #4;
  endtask

  // Model: lock owner (-1 = free), rotation pointer, locked cycles.
  int m_lock, m_ptr, m_held;

  task automatic model_check(input string tag);
    int  gi;
    bit  ef, eto;
    logic [3:0] eg;
    gi = -1; ef = 0; eto = 0;
    if (!rst) begin
      if (m_lock >= 0) gi = m_lock;
      else
        for (int k = 0; k < 4; k++)
          if (gi < 0 && req[(m_ptr + k) % 4]) gi = (m_ptr + k) % 4;
      if (gi >= 0) begin
        ef  = req[gi] && rdy;
        eto = TO_EN && m_lock >= 0 && m_held == MAXH - 1
              && !(ef && last[gi]);
      end
    end
    eg = (gi < 0) ? 4'b0 : 4'(1 << gi);
    chk({tag, " grant"}, 32'(g), 32'(eg));
    chk({tag, " id"}, 32'(gid), (gi < 0) ? 0 : 32'(gi));
    chk({tag, " valid"}, 32'(gv), 32'(gi >= 0));
    chk({tag, " fire"}, 32'(bf), 32'(ef));
    chk({tag, " timeout"}, 32'(to), 32'(eto));
    if (rst) begin
      m_lock = -1; m_ptr = 0; m_held = 0;
    end else if (gi >= 0) begin
      if ((ef && last[gi]) || eto) begin
        m_lock = -1;
        m_ptr  = (gi + 1) % 4;
      end else if (m_lock < 0) begin
        m_lock = gi;
        m_held = 0;
      end else begin
        m_held++;
      end
    end
  endtask

  typedef struct {
    bit         r;
    logic [3:0] q;
    logic [3:0] l;
    bit         y;
    logic [3:0] g;
    logic [1:0] id;
    bit         f;
  } vec_t;

  vec_t tv[$];

  function automatic void add(bit r, logic [3:0] q, logic [3:0] l,
                              bit y, logic [3:0] eg, logic [1:0] id,
                              bit f);
    vec_t v;
    v.r = r; v.q = q; v.l = l; v.y = y;
    v.g = eg; v.id = id; v.f = f;
    tv.push_back(v);
  endfunction

  initial begin
    rst = 1'b1; req = '0; last = '0; rdy = 1'b0;
    rst3 = 1'b1; req3 = '0; last3 = '0; rdy3 = 1'b0;

    // reset
    add(1, 4'hF, 4'hF, 1, 4'h0, 0, 0);
    // fairness: 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++)
      add(0, 4'hF, 4'hF, 1, 4'(1 << (i % 4)), 2'(i % 4), 1);
    // burst lock, then no-bubble handover to 1
    add(0, 4'h3, 4'h0, 1, 4'h1, 0, 1);
    add(0, 4'h3, 4'h0, 1, 4'h1, 0, 1);
    add(0, 4'h3, 4'h1, 1, 4'h1, 0, 1);
    add(0, 4'h3, 4'h2, 1, 4'h2, 1, 1);
    // backpressure on requester 2
    add(0, 4'h4, 4'h4, 0, 4'h4, 2, 0);
    add(0, 4'h4, 4'h4, 0, 4'h4, 2, 0);
    add(0, 4'h4, 4'h4, 0, 4'h4, 2, 0);
    add(0, 4'h4, 4'h4, 1, 4'h4, 2, 1);
    add(0, 4'hF, 4'hF, 1, 4'h8, 3, 1);
    // reset mid-burst
    add(0, 4'h4, 4'h0, 1, 4'h4, 2, 1);
    add(1, 4'hF, 4'hF, 1, 4'h0, 0, 0);
    add(0, 4'hF, 4'h0, 1, 4'h1, 0, 1);
    add(0, 4'h1, 4'h1, 1, 4'h1, 0, 1);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].r, tv[i].q, tv[i].l, tv[i].y);
      chk($sformatf("vec%0d grant", i), 32'(g), 32'(tv[i].g));
      chk($sformatf("vec%0d id", i), 32'(gid), 32'(tv[i].id));
      chk($sformatf("vec%0d fire", i), 32'(bf), 32'(tv[i].f));
      chk($sformatf("vec%0d valid", i), 32'(gv), 32'(|tv[i].g));
      chk($sformatf("vec%0d timeout", i), 32'(to), 32'h0);
    end

    // hold timeout: ptr=1, requester 1 never sends last
    for (int c = 0; c < (TO_EN ? 6 : 22); c++) begin
      drive(0, 4'h3, 4'h0, 1);
      chk($sformatf("hold%0d grant", c), 32'(g),
          (TO_EN && c == 5) ? 32'h1 : 32'h2);
      chk($sformatf("hold%0d timeout", c), 32'(to),
          32'(TO_EN && c == 4));
    end

    // N=3 wrap
    drive3(1, 3'b101, 3'b111);
    chk("n3 reset grant", 32'(g3), 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive3(0, 3'b101, 3'b111);
      chk($sformatf("n3 rr%0d id", i), 32'(gid3), (i % 2) ? 2 : 0);
      chk($sformatf("n3 rr%0d fire", i), 32'(bf3), 32'h1);
    end
    drive3(0, 3'b010, 3'b010);
    chk("n3 wrap id1", 32'(gid3), 32'h1);
    drive3(0, 3'b111, 3'b111);
    chk("n3 wrap id2", 32'(gid3), 32'h2);
    drive3(0, 3'b111, 3'b111);
    chk("n3 wrap id0", 32'(gid3), 32'h0);
    drive3(0, 3'b100, 3'b100);
    chk("n3 wrap grant", 32'(g3), 32'h4);
    drive3(0, 3'b001, 3'b001);
    chk("n3 after wrap", 32'(g3), 32'h1);

    // randomized run against the model
    m_lock = -1; m_ptr = 0; m_held = 0;
    drive(1, 4'h0, 4'h0, 0);
    model_check("rnd reset");
    for (int i = 0; i < 400; i++) begin
      logic [3:0] l;
      for (int b = 0; b < 4; b++) l[b] = ($urandom_range(0, 2) == 0);
      drive(($urandom_range(0, 59) == 0), 4'($urandom),
            l, ($urandom_range(0, 9) < 7));
      model_check($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_locked_burst.md
Name: rr_arbiter_locked_burst

Overview:
- N-requester round-robin arbiter for one shared downstream resource, such as a bus or a memory port.
- Each requester may own the resource for a multi-beat burst; the grant is held until the owner's final beat is accepted.
- Priority rotates so the requester after the last completed owner wins next.
- Sits between requester FSMs and the resource's valid/ready interface.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- ID_W, $clog2(N), width of grant_id; derived, not overridable.
- MAX_HOLD, 16, maximum cycles an owner may stay locked; used only with ARB_HOLD_TIMEOUT_EN; must be ≥ 2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- req  input  N  per-requester request; a beat is offered while high.
- last  input  N  per-requester flag: the offered beat is the final beat of the burst.
- res_ready  input  1  resource accepts a beat this cycle.
- grant  output  N  one-hot grant, or all-zero.
- grant_valid  output  1  OR of grant.
- grant_id  output  ID_W  index of the granted requester; 0 when grant_valid is 0.
- beat_fire  output  1  grant_valid & req[grant_id] & res_ready.
- timeout  output  1  one-cycle pulse on forced release; tied 0 when the feature is compiled out.

Behaviour:
- Registers:
  - state in {IDLE, LOCKED}.
  - ptr[ID_W], the highest-priority index.
  - owner[ID_W].
- Reset: state=IDLE, ptr=0, owner=0, hold counter=0. While rst is high, grant=0, grant_valid=0, grant_id=0, beat_fire=0, timeout=0.
- IDLE, combinational (zero-latency) grant:
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, … mod N.
  - No req: all outputs 0; state and ptr unchanged.
- IDLE transitions when a winner w exists:
  - beat_fire & last[w]: single-beat burst; stay IDLE, ptr ← (w+1) mod N.
  - Otherwise, whether res_ready is low or the beat is not last: state ← LOCKED, owner ← w. ptr is unchanged.
- LOCKED:
  - grant = onehot(owner), independent of the other requesters' req.
  - If req[owner] drops, grant stays asserted and beat_fire=0. Requesters must hold req until the last beat; the arbiter does not release early.
- LOCKED transitions:
  - beat_fire & last[owner]: state ← IDLE, ptr ← (owner+1) mod N. The next cycle arbitrates combinationally, so back-to-back bursts from different requesters have no bubble.
- Wrap-around: ptr increments modulo N. For non-power-of-2 N, ptr never holds values ≥ N.
- Simultaneous requests: resolved only by rotation from ptr; no fixed priority beyond that.
- Reset mid-burst: lock is abandoned and ptr returns to 0. The interrupted requester gets no special priority.
- last is sampled only when its beat fires; last on a non-firing beat is ignored.

Optional Feature:
- Macro: ARB_HOLD_TIMEOUT_EN.
- Defined:
  - Hold counter clears on entry to LOCKED and increments each LOCKED cycle.
  - When it reaches MAX_HOLD−1 without completion, the next edge forces state ← IDLE and ptr ← (owner+1) mod N.
  - timeout pulses high for exactly that cycle, the last cycle of the lock.
  - A completing beat_fire&last in that same cycle takes precedence: normal release, timeout=0.
- Undefined: no counter logic; timeout is constant 0; a lock is held indefinitely.

Decomposition:
- Package arb_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_LOCKED}, 1-bit logic.
  - Function onehot_to_idx and its inverse.
- Sub-module rr_priority_pick holds the combinational rotate / find-first / rotate-back. Parameter N; inputs req and ptr; outputs found, idx.
- The top level holds the FSM, ptr, owner, hold counter and output muxing.

Test Plan:
1. Fairness, N=4: after reset, req=1111, last=1111, res_ready=1 for 8 cycles → grant_id sequence 0,1,2,3,0,1,2,3, and beat_fire every cycle.
2. Burst lock: req=0011, requester 0 sends 3 beats with last on the 3rd, res_ready=1 → grant=0001 for 3 cycles, then 0010 on cycle 4 with no bubble; ptr=1 after cycle 3.
3. Backpressure: req=0100, last=1, res_ready=0 for 3 cycles, then 1 → grant=0100 throughout; state LOCKED for cycles 2–4; beat_fire only on cycle 4; ptr=3 afterward.
4. Reset mid-burst: owner=2 locked, raise rst for 1 cycle with req=1111 → grant=0 during rst; first grant afterward goes to requester 0.
5. Timeout (ARB_HOLD_TIMEOUT_EN, MAX_HOLD=4): requester 1 holds req with last=0 and req=0011 → timeout pulses exactly once; the following cycle grant=0001 (ptr=2 wraps past 2, 3 to 0); compiled out, grant stays 0010 for 20+ cycles with timeout=0.
6. Wrap with N=3: req=101 repeatedly, single beats → grant_id sequence 0,2,0,2; ptr never equals 3.
